// File: rtl/tx_delay_ch_if.sv
// Control, LUT-load and pulser signals of one transmit channel.
// The master drives LUT writes and fire requests; the channel (slave) returns pulser drive and status.
interface tx_delay_ch_if #(
  parameter int ADDR_WD = 8,
  parameter int DLY_WD  = 12,
  parameter int HALF_WD = 6,
  parameter int CYC_WD  = 4
);
  logic [ADDR_WD-1:0] lut_addr;
  logic [DLY_WD-1:0]  lut_din;
  logic               lut_we;
  logic [ADDR_WD-1:0] line_addr;
  logic [HALF_WD-1:0] half_period;
  logic [CYC_WD-1:0]  num_cycles;
  logic               start;
  logic               abort;
  logic               tx_pos;
  logic               tx_neg;
  logic               tx_en;
  logic               busy;
  logic               done;

  modport master (
    output lut_addr, lut_din, lut_we, line_addr, half_period, num_cycles, start, abort,
    input  tx_pos, tx_neg, tx_en, busy, done
  );

  modport slave (
    input  lut_addr, lut_din, lut_we, line_addr, half_period, num_cycles, start, abort,
    output tx_pos, tx_neg, tx_en, busy, done
  );
endinterface

// File: rtl/tx_delay_ch.sv
// Per-element transmit channel: LUT-selected fire delay followed by a bipolar pulser burst.
// First tx_pos rises D+2 clocks after start is sampled; start is ignored (not queued) while busy.
module tx_delay_ch #(
  parameter int ADDR_WD = 8,
  parameter int DLY_WD  = 12,
  parameter int HALF_WD = 6,
  parameter int CYC_WD  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  tx_delay_ch_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, DELAY, PULSE, DONE} state_t;

  state_t             state_q;
  logic [DLY_WD-1:0]  lut_mem [2**ADDR_WD];
  logic [DLY_WD-1:0]  rd_q;
  logic [DLY_WD-1:0]  dly_q;
  logic [HALF_WD-1:0] h_q;
  logic [HALF_WD-1:0] half_q;
  logic [CYC_WD-1:0]  n_last_q;
  logic [CYC_WD-1:0]  cyc_q;
  logic               tx_pos_q;
  logic               tx_neg_q;
  logic               tx_en_q;
  logic               busy_q;
  logic               done_q;

  logic [HALF_WD-1:0] h_d;
  logic [CYC_WD-1:0]  n_last_d;

  // Zero half-period or cycle count behaves as one.
  always_comb begin
    h_d      = (bus.half_period == '0) ? HALF_WD'(1) : bus.half_period;
    n_last_d = (bus.num_cycles == '0) ? '0 : bus.num_cycles - CYC_WD'(1);
  end

  // LUT survives reset, so it lives outside the reset domain.
  always_ff @(posedge clk) begin
    if (bus.lut_we && state_q == IDLE) begin
      lut_mem[bus.lut_addr] <= bus.lut_din;
    end
    if (bus.start && state_q == IDLE) begin
      rd_q <= lut_mem[bus.line_addr];
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= IDLE;
      dly_q    <= '0;
      h_q      <= '0;
      half_q   <= '0;
      n_last_q <= '0;
      cyc_q    <= '0;
      tx_pos_q <= 1'b0;
      tx_neg_q <= 1'b0;
      tx_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.abort && state_q != IDLE) begin
      state_q  <= IDLE;
      tx_pos_q <= 1'b0;
      tx_neg_q <= 1'b0;
      tx_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q  <= LOAD;
            busy_q   <= 1'b1;
            h_q      <= h_d;
            n_last_q <= n_last_d;
          end
        end
        LOAD: begin
          tx_en_q <= 1'b1;
          half_q  <= '0;
          cyc_q   <= '0;
          if (rd_q == '0) begin
            state_q <= PULSE;
          end else begin
            state_q <= DELAY;
            dly_q   <= rd_q;
          end
        end
        DELAY: begin
          if (dly_q == DLY_WD'(1)) begin
            state_q <= PULSE;
          end else begin
            dly_q <= dly_q - DLY_WD'(1);
          end
        end
        PULSE: begin
          // The PULSE entry cycle has both drives low; the first edge in PULSE launches tx_pos.
          if (!tx_pos_q && !tx_neg_q) begin
            tx_pos_q <= 1'b1;
            half_q   <= HALF_WD'(1);
          end else if (half_q == h_q) begin
            half_q <= HALF_WD'(1);
            if (tx_pos_q) begin
              tx_pos_q <= 1'b0;
              tx_neg_q <= 1'b1;
            end else if (cyc_q == n_last_q) begin
              state_q  <= DONE;
              tx_neg_q <= 1'b0;
              tx_en_q  <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              cyc_q    <= cyc_q + CYC_WD'(1);
              tx_neg_q <= 1'b0;
              tx_pos_q <= 1'b1;
            end
          end else begin
            half_q <= half_q + HALF_WD'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_pos = tx_pos_q;
  assign bus.tx_neg = tx_neg_q;
  assign bus.tx_en  = tx_en_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_tx_delay_ch.sv
// Directed bench for tx_delay_ch: output traces are captured per clock and compared against hand-built bit masks.
module tb_tx_delay_ch;
  localparam int ADDR_WD = 8;
  localparam int DLY_WD  = 12;
  localparam int HALF_WD = 6;
  localparam int CYC_WD  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  tx_delay_ch_if #(.ADDR_WD(ADDR_WD), .DLY_WD(DLY_WD), .HALF_WD(HALF_WD), .CYC_WD(CYC_WD)) bus ();

  tx_delay_ch #(.ADDR_WD(ADDR_WD), .DLY_WD(DLY_WD), .HALF_WD(HALF_WD), .CYC_WD(CYC_WD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [127:0] c_pos, c_neg, c_en, c_done, c_busy;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] rng(input int lo, input int hi);
    logic [127:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lut_wr(input int a, input int d);
    bus.lut_addr = ADDR_WD'(a);
    bus.lut_din  = DLY_WD'(d);
    bus.lut_we   = 1'b1;
    step();
    bus.lut_we   = 1'b0;
  endtask

  // Returns at the sample point just after edge k; inputs are then scrambled mid-burst.
  task automatic fire(input int line, input int h, input int n);
    bus.line_addr   = ADDR_WD'(line);
    bus.half_period = HALF_WD'(h);
    bus.num_cycles  = CYC_WD'(n);
    bus.start       = 1'b1;
    step();
    bus.start       = 1'b0;
    bus.line_addr   = ADDR_WD'($urandom);
    bus.half_period = HALF_WD'($urandom);
    bus.num_cycles  = CYC_WD'($urandom);
  endtask

  task automatic capture(input int skip, input int len, input int poke_j, input int abort_j);
    c_pos = '0; c_neg = '0; c_en = '0; c_done = '0; c_busy = '0;
    for (int j = 0; j < skip + len; j++) begin
      if (j >= skip) begin
        c_pos[j-skip]  = bus.tx_pos;
        c_neg[j-skip]  = bus.tx_neg;
        c_en[j-skip]   = bus.tx_en;
        c_done[j-skip] = bus.done;
        c_busy[j-skip] = bus.busy;
      end
      if (j == poke_j) begin
        bus.start     = 1'b1;
        bus.line_addr = '0;
        bus.lut_addr  = ADDR_WD'(5);
        bus.lut_din   = DLY_WD'(3);
        bus.lut_we    = 1'b1;
      end
      if (j == poke_j + 1) begin
        bus.start  = 1'b0;
        bus.lut_we = 1'b0;
      end
      if (j == abort_j)     bus.abort = 1'b1;
      if (j == abort_j + 1) bus.abort = 1'b0;
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.lut_addr = '0; bus.lut_din = '0; bus.lut_we = 1'b0;
    bus.line_addr = '0; bus.half_period = '0; bus.num_cycles = '0;
    bus.start = 1'b0; bus.abort = 1'b0;

    step(); step();
    check("rst_pos",  128'(bus.tx_pos), 128'(0));
    check("rst_neg",  128'(bus.tx_neg), 128'(0));
    check("rst_en",   128'(bus.tx_en),  128'(0));
    check("rst_busy", 128'(bus.busy),   128'(0));
    check("rst_done", 128'(bus.done),   128'(0));
    rst_n = 1'b0;
    step();
    check("idle_busy", 128'(bus.busy), 128'(0));

    // D=10, H=3, N=2
    lut_wr(5, 10);
    lut_wr(0, 0);
    lut_wr(7, 100);
    lut_wr(255, 4095);
    fire(5, 3, 2);
    capture(0, 32, -1, -1);
    check("t1_pos",  c_pos,  rng(12, 14) | rng(18, 20));
    check("t1_neg",  c_neg,  rng(15, 17) | rng(21, 23));
    check("t1_done", c_done, rng(24, 24));
    check("t1_en",   c_en,   rng(1, 23));
    check("t1_busy", c_busy, rng(0, 24));

    // D=0, H=1, N=1
    fire(0, 1, 1);
    capture(0, 8, -1, -1);
    check("t2_pos",  c_pos,  rng(2, 2));
    check("t2_neg",  c_neg,  rng(3, 3));
    check("t2_done", c_done, rng(4, 4));
    check("t2_en",   c_en,   rng(1, 3));
    check("t2_busy", c_busy, rng(0, 4));

    // start and LUT write while busy are both dropped
    fire(5, 1, 1);
    capture(0, 20, 4, -1);
    check("t3_pos",  c_pos,  rng(12, 12));
    check("t3_neg",  c_neg,  rng(13, 13));
    check("t3_done", c_done, rng(14, 14));
    check("t3_busy", c_busy, rng(0, 14));
    fire(5, 1, 1);
    capture(0, 20, -1, -1);
    check("t3_refire_pos", c_pos, rng(12, 12));

    // abort during a 100-clock delay
    fire(7, 2, 3);
    capture(0, 120, -1, 20);
    check("t4_pos",  c_pos,  128'(0));
    check("t4_done", c_done, 128'(0));
    check("t4_en",   c_en,   rng(1, 20));
    check("t4_busy", c_busy, rng(0, 20));
    fire(0, 1, 1);
    capture(0, 8, -1, -1);
    check("t4_after_pos",  c_pos,  rng(2, 2));
    check("t4_after_done", c_done, rng(4, 4));

    // async reset mid-pulse
    fire(0, 4, 3);
    step(); step(); step();
    check("t5_pre_pos", 128'(bus.tx_pos), 128'(1));
    #2;
    rst_n = 1'b1;
    #1;
    check("t5_async_pos", 128'(bus.tx_pos), 128'(0));
    check("t5_async_neg", 128'(bus.tx_neg), 128'(0));
    check("t5_async_en",  128'(bus.tx_en),  128'(0));
    step(); step();
    rst_n = 1'b0;
    step();
    fire(5, 1, 1);
    capture(0, 20, -1, -1);
    check("t5_lut_pos", c_pos, rng(12, 12));

    // maximum delay with H=0, N=0
    fire(255, 0, 0);
    capture(4090, 20, -1, -1);
    check("t6_pos",  c_pos,  rng(7, 7));
    check("t6_neg",  c_neg,  rng(8, 8));
    check("t6_done", c_done, rng(9, 9));
    check("t6_en",   c_en,   rng(0, 8));
    check("t6_busy", c_busy, rng(0, 9));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tx_delay_ch.md
Name: tx_delay_ch

Overview:
Transmit-side beamforming channel, the mirror of the per-channel receive delay path. A per-scan-line transmit delay LUT is loaded over the same address/write-enable bus used by the receive LUTs. On `start`, the block looks up the delay for the selected line, waits that many clocks, then drives a bipolar pulser burst (`tx_pos`/`tx_neg`). `tx_en` is exported to gate the receive channels while transmit is in progress. One instance sits per element, alongside the receive channel.

Parameters:
- ADDR_WD, 8, LUT address width (2^ADDR_WD scan lines)
- DLY_WD, 12, transmit delay width in clocks
- HALF_WD, 6, pulse half-period width in clocks
- CYC_WD, 4, burst cycle-count width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-high (asserted = 1); clears all state
- lut_addr  in  ADDR_WD  LUT write address
- lut_din  in  DLY_WD  LUT write data (delay in clocks)
- lut_we  in  1  LUT write strobe
- line_addr  in  ADDR_WD  scan line to fire, sampled with start
- half_period  in  HALF_WD  pulse half-period H, sampled with start
- num_cycles  in  CYC_WD  burst cycles N, sampled with start
- start  in  1  fire request, single-cycle
- abort  in  1  synchronous cancel
- tx_pos  out  1  pulser positive drive
- tx_neg  out  1  pulser negative drive
- tx_en  out  1  transmit active
- busy  out  1  state != IDLE
- done  out  1  one-cycle burst-complete pulse

Behaviour:
- **Reset:** state IDLE; tx_pos, tx_neg, tx_en, busy and done all 0. Counters are 0. LUT contents are not cleared.
- **LUT:** 2^ADDR_WD x DLY_WD, synchronous write and 1-cycle synchronous read.
  - Writes are accepted only in IDLE; `lut_we` in any other state is ignored.
- **Registered outputs:** all outputs are registered.
- **FSM states:** IDLE, LOAD, DELAY, PULSE, DONE.
  - **IDLE:** when `start`=1 at edge k, latch line_addr, H and N.
    - H=0 is treated as 1; N=0 is treated as 1.
    - Issue the LUT read, go to LOAD, and set tx_en=1 from edge k+1.
  - **LOAD:** latch the LUT output as D.
    - D=0: go to PULSE.
    - D>0: go to DELAY and count D clocks.
  - **Pulse timing:** tx_pos first rises at edge k+2+D.
  - **PULSE:** each cycle is H clocks with tx_pos=1, then H clocks with tx_neg=1. Repeat N times, for 2*H*N clocks total.
    - tx_pos and tx_neg are never both 1.
    - There is no gap between cycles.
  - **DONE:** entered at edge k+2+D+2HN.
    - tx_pos=tx_neg=0, tx_en=0, done=1 for exactly one cycle.
    - Then return to IDLE.
- **busy:** 1 in LOAD, DELAY, PULSE and DONE.
- **start while busy:** ignored, not queued. `start` in the DONE cycle is also ignored.
- **abort (any non-IDLE state):** next edge goes to IDLE.
  - All outputs go to 0; done is not asserted.
  - abort has priority over start and over every state transition.
  - abort in IDLE has no effect.
- **Reset mid-operation:** all outputs drop to 0 immediately, without waiting for a clock edge. After release the block is in IDLE, and the LUT retains its data.
- **Counter widths:**
  - Delay counter is DLY_WD bits; the maximum D = 2^DLY_WD-1 must be honoured with no wrap.
  - Half-period counter is HALF_WD bits; cycle counter is CYC_WD bits.
- **Input changes during a burst:** changes to H, N or line_addr have no effect on the burst in progress.

Test Plan:
1. Write LUT[5]=10; start at edge k with line 5, H=3, N=2.
   -> tx_pos=1 at k+12..k+14, tx_neg=1 at k+15..k+17, tx_pos=1 at k+18..k+20, tx_neg=1 at k+21..k+23.
   -> done=1 and tx_en=0 at k+24; tx_en=1 over k+1..k+23.
2. LUT[0]=0, H=1, N=1, start at k.
   -> tx_pos=1 at k+2, tx_neg=1 at k+3, done at k+4.
3. Fire LUT[5]=10 (H=1, N=1). Pulse start again at k+5, and lut_we at k+5 writing LUT[5]=3.
   -> no restart; a second fire after done still shows D=10 (tx_pos at k'+12).
4. Fire with D=100; assert abort at k+20.
   -> at k+21 busy=0, tx_en=0; done never asserted; an immediate new start works normally.
5. Assert rst_n during PULSE.
   -> tx_pos, tx_neg and tx_en are 0 before the next clk edge. After release and a re-fire, the LUT values are intact.
6. H=0, N=0, D=4095.
   -> tx_pos at k+4097 for 1 clock, tx_neg for 1 clock, done at k+4099.
